// File: rtl/nonce_fifo_serializer_pkg.sv
// nonce_buf_pkg: shared state encoding and width helper for the nonce FIFO serializer
package nonce_buf_pkg;
  typedef enum logic {S_IDLE, S_SHIFT} nb_state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/nonce_fifo_serializer_if.sv
// nonce_fifo_serializer_if: result-path and serial-side signals of the nonce FIFO serializer
interface nonce_fifo_serializer_if import nonce_buf_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) ();
  localparam int CW = cnt_w(DEPTH);
  logic valid;
  logic success;
  logic [WIDTH-1:0] nonce_i;
  logic valid_o;
  logic success_o;
  logic readready;
  logic nonce_o;
  logic nonce_vld_o;
  logic [CW-1:0] count_o;
  logic full_o;
  logic empty_o;
  logic clear_err;
  logic overflow_o;
  logic underflow_o;
  logic error;
  modport master (
    output valid, success, nonce_i, readready, clear_err,
    input valid_o, success_o, nonce_o, nonce_vld_o, count_o, full_o, empty_o,
          overflow_o, underflow_o, error
  );
  modport slave (
    input valid, success, nonce_i, readready, clear_err,
    output valid_o, success_o, nonce_o, nonce_vld_o, count_o, full_o, empty_o,
           overflow_o, underflow_o, error
  );
endinterface

// File: rtl/nonce_fifo_serializer_mem.sv
// nonce_fifo_mem: WIDTH x DEPTH register FIFO; a push while full is taken only alongside a pop
module nonce_fifo_mem import nonce_buf_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic wr;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign wr    = push && (!full || pop);
  assign head  = mem_q[rptr_q];
  assign count = count_q;
  always_comb begin
    wptr_d  = wptr_q + AW'(wr);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(wr) - CW'(pop);
  end
  always_ff @(posedge clk) if (wr) mem_q[wptr_q] <= din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/nonce_fifo_serializer.sv
// nonce_fifo_serializer: buffers winning nonces in a FIFO and shifts the head out bit-serially
module nonce_fifo_serializer import nonce_buf_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic clk,
  input logic rst_n,
  nonce_fifo_serializer_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = cnt_w(DEPTH);
  nb_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, sel;
  logic [WIDTH-1:0] head;
  logic [CW-1:0] count;
  logic full, empty, push, pop, shifting, last, start;
  logic valid_q, success_q, ovf_q, ovf_d, udf_q, udf_d;
  assign push     = bus.valid && bus.success;
  assign shifting = state_q == S_SHIFT;
  assign last     = idx_q == IW'(WIDTH - 1);
  assign start    = bus.readready && !empty;
  assign sel      = MSB_FIRST ? IW'(WIDTH - 1) - idx_q : idx_q;
  nonce_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(bus.nonce_i),
    .head(head), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = '0;
    pop     = 1'b0;
    if (shifting) begin
      pop     = last;
      state_d = last ? S_IDLE : S_SHIFT;
      idx_d   = last ? '0 : idx_q + IW'(1);
    end else if (start) state_d = S_SHIFT;
  end
  // A full FIFO still accepts a push on the edge that pops the head.
  always_comb begin
    ovf_d = (push && full && !pop) || (ovf_q && !bus.clear_err);
    udf_d = (bus.readready && (shifting || empty)) || (udf_q && !bus.clear_err);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      success_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= bus.valid;
      success_q <= bus.success;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end
  assign bus.valid_o     = valid_q;
  assign bus.success_o   = success_q;
  assign bus.nonce_vld_o = shifting;
  assign bus.nonce_o     = shifting && head[sel];
  assign bus.count_o     = count;
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = udf_q;
  assign bus.error       = ovf_q || udf_q;
endmodule

// File: tb/tb_nonce_fifo_serializer.sv
// tb_nonce_fifo_serializer: directed checks of FIFO capture, serial shift-out and sticky flags
module tb_nonce_fifo_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errs = 0;
  logic [31:0] w;
  int n;
  logic [31:0] exp4 [4];
  always #5 clk = ~clk;
  nonce_fifo_serializer_if #(.WIDTH(32), .DEPTH(4)) ba ();
  nonce_fifo_serializer_if #(.WIDTH(32), .DEPTH(4)) bb ();
  nonce_fifo_serializer #(.WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ba));
  nonce_fifo_serializer #(.WIDTH(32), .DEPTH(4), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] v);
    ba.valid = 1'b1; ba.success = 1'b1; ba.nonce_i = v;
    tick();
    ba.valid = 1'b0; ba.success = 1'b0;
  endtask

  task automatic read_a(output logic [31:0] r, output int c);
    r = '0; c = 0;
    ba.readready = 1'b1;
    tick();
    ba.readready = 1'b0;
    while (ba.nonce_vld_o && c < 40) begin
      if (c < 32) r[c] = ba.nonce_o;
      c++;
      tick();
    end
  endtask

  task automatic read_b(input logic [31:0] v, output logic [31:0] s, output int c);
    bb.valid = 1'b1; bb.success = 1'b1; bb.nonce_i = v;
    tick();
    bb.valid = 1'b0; bb.success = 1'b0;
    s = '0; c = 0;
    bb.readready = 1'b1;
    tick();
    bb.readready = 1'b0;
    while (bb.nonce_vld_o && c < 40) begin
      if (c < 32) s[c] = bb.nonce_o;
      c++;
      tick();
    end
  endtask

  initial begin
    ba.valid = 0; ba.success = 0; ba.nonce_i = '0; ba.readready = 0; ba.clear_err = 0;
    bb.valid = 0; bb.success = 0; bb.nonce_i = '0; bb.readready = 0; bb.clear_err = 0;
    #12;
    chk("rst_count", 32'(ba.count_o), 0);
    chk("rst_empty", 32'(ba.empty_o), 1);
    chk("rst_full", 32'(ba.full_o), 0);
    chk("rst_vld", 32'(ba.nonce_vld_o), 0);
    chk("rst_error", 32'(ba.error), 0);
    chk("rst_valid_o", 32'(ba.valid_o), 0);
    #10 rst_n = 1'b1;
    tick();
    ba.valid = 1'b1;
    tick();
    ba.valid = 1'b0;
    chk("pass_valid_o", 32'(ba.valid_o), 1);
    chk("pass_success_o", 32'(ba.success_o), 0);
    chk("nopush_count", 32'(ba.count_o), 0);
    push_a(32'hDEADBEEF);
    chk("t1_success_o", 32'(ba.success_o), 1);
    chk("t1_count", 32'(ba.count_o), 1);
    read_a(w, n);
    chk("t1_word", w, 32'hDEADBEEF);
    chk("t1_len", 32'(n), 32);
    chk("t1_empty", 32'(ba.empty_o), 1);
    chk("t1_idle_bit", 32'(ba.nonce_o), 0);
    for (int i = 1; i <= 5; i++) push_a(32'(i));
    chk("t2_count", 32'(ba.count_o), 4);
    chk("t2_full", 32'(ba.full_o), 1);
    chk("t2_overflow", 32'(ba.overflow_o), 1);
    chk("t2_error", 32'(ba.error), 1);
    for (int i = 1; i <= 4; i++) begin
      read_a(w, n);
      chk("t2_word", w, 32'(i));
      chk("t2_len", 32'(n), 32);
    end
    chk("t2_empty", 32'(ba.empty_o), 1);
    ba.clear_err = 1'b1;
    tick();
    ba.clear_err = 1'b0;
    chk("t2_clr_ovf", 32'(ba.overflow_o), 0);
    chk("t2_clr_err", 32'(ba.error), 0);
    push_a(32'h0000FFFF);
    ba.readready = 1'b1;
    tick();
    w = '0; n = 0;
    for (int i = 0; i < 32; i++) begin
      w[i] = ba.nonce_o;
      n += 32'(ba.nonce_vld_o);
      ba.readready = (i == 5);
      tick();
    end
    ba.readready = 1'b0;
    chk("t3_word", w, 32'h0000FFFF);
    chk("t3_len", 32'(n), 32);
    chk("t3_done", 32'(ba.nonce_vld_o), 0);
    chk("t3_underflow", 32'(ba.underflow_o), 1);
    ba.clear_err = 1'b1;
    tick();
    ba.clear_err = 1'b0;
    chk("t3_clr_udf", 32'(ba.underflow_o), 0);
    ba.readready = 1'b1;
    tick();
    ba.readready = 1'b0;
    chk("t3_empty_udf", 32'(ba.underflow_o), 1);
    chk("t3_empty_vld", 32'(ba.nonce_vld_o), 0);
    ba.clear_err = 1'b1; ba.readready = 1'b1;
    tick();
    ba.readready = 1'b0;
    chk("t3_clr_coincide", 32'(ba.underflow_o), 1);
    tick();
    ba.clear_err = 1'b0;
    chk("t3_clr_after", 32'(ba.underflow_o), 0);
    push_a(32'h11); push_a(32'h22); push_a(32'h33); push_a(32'h44);
    chk("t4_full", 32'(ba.full_o), 1);
    ba.readready = 1'b1;
    tick();
    ba.readready = 1'b0;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      w[i] = ba.nonce_o;
      if (i == 31) begin
        ba.valid = 1'b1; ba.success = 1'b1; ba.nonce_i = 32'h55;
      end
      tick();
    end
    ba.valid = 1'b0; ba.success = 1'b0;
    chk("t4_word", w, 32'h11);
    chk("t4_count", 32'(ba.count_o), 4);
    chk("t4_overflow", 32'(ba.overflow_o), 0);
    exp4 = '{32'h22, 32'h33, 32'h44, 32'h55};
    for (int i = 0; i < 4; i++) begin
      read_a(w, n);
      chk("t4_drain", w, exp4[i]);
    end
    chk("t4_empty", 32'(ba.empty_o), 1);
    push_a(32'h12345678);
    ba.readready = 1'b1;
    tick();
    ba.readready = 1'b0;
    tick();
    tick();
    chk("t5_inshift", 32'(ba.nonce_vld_o), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 32'(ba.nonce_vld_o), 0);
    chk("t5_rst_bit", 32'(ba.nonce_o), 0);
    chk("t5_rst_count", 32'(ba.count_o), 0);
    chk("t5_rst_empty", 32'(ba.empty_o), 1);
    #3 rst_n = 1'b1;
    tick();
    chk("t5_post_count", 32'(ba.count_o), 0);
    chk("t5_post_vld", 32'(ba.nonce_vld_o), 0);
    read_b(32'h80000001, w, n);
    chk("t6_first", 32'(w[0]), 1);
    chk("t6_middle", 32'(w[30:1]), 0);
    chk("t6_last", 32'(w[31]), 1);
    chk("t6_len", 32'(n), 32);
    read_b(32'h00000003, w, n);
    chk("t6_order", w, 32'hC0000000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
